dmem_arbiter: RTL and testbench

Two-port arbiter for the single-ported data memory. It shares the memory between the pipeline's MEM stage and a DMA/debug-loader port (UART program loader, test harness). The CPU normally has zero-latency priority. A bounded-starvation rule lets a waiting DMA request steal one cycle, and the arbiter stalls the pipeline for that cycle. It sits between the EX/MEM register outputs and the DataMemory instance, after peripheral-address decode.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_starve_counter.sv | 30 +++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: grant and response-state encodings
// plus the starvation counter width. Imported by every arbiter file.
// Pure declarations; no logic, no latency.
package dmem_arb_pkg;

  // Wide enough for any legal starvation limit (1..15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_CPU  = 2'd1,
    GRANT_DMA  = 2'd2
  } grant_e;

  typedef enum logic {
    RESP_IDLE = 1'b0,
    RESP_RD   = 1'b1
  } resp_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU-side, DMA-side and DataMemory-side signals around the arbiter.
// slave modport = the arbiter; master modport = CPU/DMA/memory environment.
// No storage; purely a connection bundle.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_valid;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ready;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive cycles a DMA request has been refused.
// at_limit is combinational from the count register; clear beats increment.
// Holds at the limit until cleared, so the forced grant stays asserted.
module dmem_starve_counter
  import dmem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_at_limit
);

  logic [CNT_W-1:0] r_cnt;

  // Count refused cycles, saturate at the limit, restart on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage and a DMA port.
// CPU path is zero-latency; DMA read data returns one cycle after acceptance.
// Macro DMEM_ARB_FAIRNESS_EN: when defined, a starved DMA request steals one cycle and stalls the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  logic              w_cpu_access;
  logic              w_force;
  logic              w_dma_ready;
  logic              w_rd_accept;
  grant_e            w_grant;
  resp_e             r_state;
  logic [DATA_W-1:0] r_rdata;

  assign w_cpu_access = bus.cpu_read | bus.cpu_write;

`ifdef DMEM_ARB_FAIRNESS_EN
  logic w_at_limit;

  // A handshake or a withdrawn request both restart the starvation count.
  dmem_starve_counter u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (bus.dma_valid & ~w_dma_ready),
    .i_clr      (~bus.dma_valid | w_dma_ready),
    .i_limit    (CNT_W'(STARVE_MAX)),
    .o_at_limit (w_at_limit)
  );

  assign w_force = bus.dma_valid & w_at_limit;
`else
  // Strict CPU priority: DMA only gets cycles the CPU leaves idle.
  assign w_force = 1'b0;
`endif

  // Pick the memory owner for this cycle; nobody owns it while in reset.
  always_comb begin
    w_grant = GRANT_NONE;
    if (reset) begin
      w_grant = GRANT_NONE;
    end else if (bus.dma_valid && (!w_cpu_access || w_force)) begin
      w_grant = GRANT_DMA;
    end else if (w_cpu_access) begin
      w_grant = GRANT_CPU;
    end
  end

  // Steer the memory port to the granted requester; idle defaults to the CPU bus with no strobes.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    case (w_grant)
      GRANT_DMA: begin
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.mem_write = bus.dma_we;
        bus.mem_read  = ~bus.dma_we;
      end
      GRANT_CPU: begin
        bus.mem_write = bus.cpu_write;
        bus.mem_read  = bus.cpu_read;
      end
      default: begin
      end
    endcase
  end

  assign w_dma_ready   = (w_grant == GRANT_DMA);
  assign w_rd_accept   = bus.dma_valid & w_dma_ready & ~bus.dma_we;
  assign bus.dma_ready = w_dma_ready;
  assign bus.cpu_stall = w_cpu_access & w_force & ~reset;
  assign bus.cpu_rdata = bus.mem_rdata;

  // Response FSM: capture DMA read data at acceptance, present it for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESP_IDLE;
      r_rdata <= '0;
    end else if (w_rd_accept) begin
      r_state <= RESP_RD;
      r_rdata <= bus.mem_rdata;
    end else begin
      r_state <= RESP_IDLE;
    end
  end

  assign bus.dma_rvalid = (r_state == RESP_RD);
  assign bus.dma_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes per-cycle expectations and DMA read data,
// a negedge monitor pops and compares them against the DUT.
// Expectations follow the build: DMEM_ARB_FAIRNESS_EN selects fair or strict-priority values.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    logic        ready;
    logic        stall;
    logic        chk_cpu;
    logic [31:0] cpu_rdata;
    logic        chk_rst;
  } exp_t;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:511];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: per-cycle control checks plus DMA read-response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dma_ready", {31'd0, bus.dma_ready}, {31'd0, e.ready});
      chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, e.stall});
      if (e.chk_cpu) chk("cpu_rdata", bus.cpu_rdata, e.cpu_rdata);
      if (e.chk_rst) begin
        chk("rst_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
        chk("rst_rdata", bus.dma_rdata, 32'd0);
        chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
      end
    end
    if (bus.dma_rvalid) begin
      if (rd_q.size() > 0) chk("dma_rdata", bus.dma_rdata, rd_q.pop_front());
      else chk("unexpected_rvalid", 32'd1, 32'd0);
    end
  end

  // One clock of stimulus with its hand-computed expectation.
  task automatic cyc(input logic rst,
                     input logic crd, input logic cwr, input logic [8:0] caddr, input logic [31:0] cwd,
                     input logic dv, input logic dwe, input logic [8:0] daddr, input logic [31:0] dwd,
                     input logic e_ready, input logic e_stall,
                     input logic chk_cpu, input logic [31:0] e_cpu,
                     input logic chk_rst, input logic push_rd, input logic [31:0] e_rd);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.cpu_read  = crd;
    bus.cpu_write = cwr;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.dma_valid = dv;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwd;
    e.ready = e_ready; e.stall = e_stall; e.chk_cpu = chk_cpu; e.cpu_rdata = e_cpu; e.chk_rst = chk_rst;
    exp_q.push_back(e);
    if (push_rd) rd_q.push_back(e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic f;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    reset = 1'b1;
    bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_valid = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;

    // Reset held with requests present: nothing granted, outputs cleared.
    cyc(1, 1,0,9'h010,0, 1,0,9'h010,0, 0,0, 0,0, 1, 0,0);
    cyc(1, 1,0,9'h010,0, 1,0,9'h010,0, 0,0, 0,0, 1, 0,0);

    // CPU only: store then load, zero-latency read back.
    cyc(0, 0,1,9'h010,32'hDEADBEEF, 0,0,0,0, 0,0, 0,0, 0, 0,0);
    cyc(0, 1,0,9'h010,0, 0,0,0,0, 0,0, 1,32'hDEADBEEF, 0, 0,0);

    // DMA only: write 0x011, then back-to-back reads of 0x010 and 0x011.
    cyc(0, 0,0,0,0, 1,1,9'h011,32'hCAFE0001, 1,0, 0,0, 0, 0,0);
    cyc(0, 0,0,0,0, 1,0,9'h010,0, 1,0, 0,0, 0, 1,32'hDEADBEEF);
    cyc(0, 0,0,0,0, 1,0,9'h011,0, 1,0, 0,0, 0, 1,32'hCAFE0001);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0, 0,0);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0, 0,0);

    // Starvation: CPU loads every cycle, DMA read held; forced grant at cycles 4 and 9 when fair.
    for (int i = 0; i < 10; i++) begin
      f = FAIR && (i == 4 || i == 9);
      cyc(0, 1,0,9'h010,0, 1,0,9'h011,0, f,f, !f,32'hDEADBEEF, 0, f,32'hCAFE0001);
    end
    // CPU goes idle: DMA served in either build.
    cyc(0, 0,0,0,0, 1,0,9'h011,0, 1,0, 0,0, 0, 1,32'hCAFE0001);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0, 0,0);

    // Same-address collision at 0x020: DMA write 0x1111 vs CPU store 0x2222.
    for (int i = 0; i < 4; i++)
      cyc(0, 1,0,9'h030,0, 1,1,9'h020,32'h1111, 0,0, 1,32'h0, 0, 0,0);
    cyc(0, 0,1,9'h020,32'h2222, 1,1,9'h020,32'h1111, FAIR,FAIR, 0,0, 0, 0,0);
    if (FAIR) cyc(0, 0,1,9'h020,32'h2222, 0,0,0,0, 0,0, 0,0, 0, 0,0);
    else      cyc(0, 0,0,0,0, 1,1,9'h020,32'h1111, 1,0, 0,0, 0, 0,0);
    cyc(0, 1,0,9'h020,0, 0,0,0,0, 0,0, 1,(FAIR ? 32'h2222 : 32'h1111), 0, 0,0);

    // Reset the cycle after a DMA read is accepted: response discarded.
    cyc(0, 0,0,0,0, 1,0,9'h010,0, 1,0, 0,0, 0, 0,0);
    cyc(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1, 0,0);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1, 0,0);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1, 0,0);

    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rd_queue_drained", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
